// File: rtl/regfile_writeback_queue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : regfile_writeback_queue_if
// Purpose  : Bundles the producer handshake, the register-file write port,
//            the operand forwarding lookups and the occupancy count of the
//            write-back queue.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface regfile_writeback_queue_if #(
  parameter int PTR_W = 2
);
  // Producer side
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_reg;
  logic [31:0]      in_data;
  // Register-file write port
  logic             drain_en;
  logic             regWrite;
  logic [4:0]       writeReg;
  logic [31:0]      writeData;
  // Operand forwarding
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             rs_hit;
  logic [31:0]      rs_fwd;
  logic             rt_hit;
  logic [31:0]      rt_fwd;
  // Occupancy
  logic [PTR_W:0]   count;

  // Pipeline side that issues requests and reads operands
  modport master (
    output in_valid, in_reg, in_data, drain_en, rs, rt,
    input  in_ready, regWrite, writeReg, writeData,
    input  rs_hit, rs_fwd, rt_hit, rt_fwd, count
  );

  // Queue side
  modport slave (
    input  in_valid, in_reg, in_data, drain_en, rs, rt,
    output in_ready, regWrite, writeReg, writeData,
    output rs_hit, rs_fwd, rt_hit, rt_fwd, count
  );
endinterface
`default_nettype wire

// File: rtl/regfile_writeback_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : regfile_writeback_queue
// Purpose  : Circular queue of pending register writes from multi-cycle
//            producers, drained one per cycle into a registered write port,
//            with combinational forwarding of pending values to rs/rt.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,   // asynchronous, active-low
  regfile_writeback_queue_if.slave   bus
);

  localparam logic [PTR_W:0] c_DEPTH_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] c_PTR_ONE   = (PTR_W + 1)'(1);

  // Queue storage and bookkeeping; pointers carry an extra wrap bit
  logic [4:0]       r_reg  [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PTR_W:0]   r_head;
  logic [PTR_W:0]   r_tail;

  // Output stage feeding the register file
  logic             r_regwrite;
  logic [4:0]       r_writereg;
  logic [31:0]      r_writedata;

  logic [PTR_W:0]   w_count;
  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_head_idx;
  logic [PTR_W-1:0] w_tail_idx;
  logic [PTR_W-1:0] w_scan_idx;
  logic             w_rs_hit;
  logic [31:0]      w_rs_fwd;
  logic             w_rt_hit;
  logic [31:0]      w_rt_fwd;

  assign w_head_idx = r_head[PTR_W-1:0];
  assign w_tail_idx = r_tail[PTR_W-1:0];
  // Wrap bit makes tail-head distinguish full (DEPTH) from empty (0)
  assign w_count    = r_tail - r_head;
  // Readiness deliberately ignores a same-cycle pop
  assign w_ready    = (w_count != c_DEPTH_CNT);
  assign w_push     = bus.in_valid && w_ready;
  assign w_pop      = bus.drain_en && (w_count != '0);

  // Pointer and entry-valid bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_vld  <= '0;
    end else begin
      // Push and pop never target the same slot: a pop needs count>0 and a
      // push needs count<DEPTH, so with both active head != tail.
      if (w_push) begin
        r_vld[w_tail_idx] <= 1'b1;
        r_tail            <= r_tail + c_PTR_ONE;
      end
      if (w_pop) begin
        r_vld[w_head_idx] <= 1'b0;
        r_head            <= r_head + c_PTR_ONE;
      end
    end
  end

  // Entry payload capture at the tail slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_reg[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (w_push) begin
      r_reg[w_tail_idx]  <= bus.in_reg;
      r_data[w_tail_idx] <= bus.in_data;
    end
  end

  // Output stage: strobe for one cycle per pop, hold index/data otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regwrite  <= 1'b0;
      r_writereg  <= '0;
      r_writedata <= '0;
    end else if (w_pop) begin
      r_regwrite  <= 1'b1;
      r_writereg  <= r_reg[w_head_idx];
      r_writedata <= r_data[w_head_idx];
    end else begin
      r_regwrite  <= 1'b0;
    end
  end

  // Forwarding lookup: seed with the output stage, then scan queue entries
  // oldest to youngest so the youngest match overrides everything older
  always_comb begin
    w_rs_hit   = r_regwrite && (r_writereg == bus.rs);
    w_rs_fwd   = w_rs_hit ? r_writedata : 32'd0;
    w_rt_hit   = r_regwrite && (r_writereg == bus.rt);
    w_rt_fwd   = w_rt_hit ? r_writedata : 32'd0;
    w_scan_idx = w_head_idx;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan_idx = w_head_idx + PTR_W'(k);
      if (r_vld[w_scan_idx] && (r_reg[w_scan_idx] == bus.rs)) begin
        w_rs_hit = 1'b1;
        w_rs_fwd = r_data[w_scan_idx];
      end
      if (r_vld[w_scan_idx] && (r_reg[w_scan_idx] == bus.rt)) begin
        w_rt_hit = 1'b1;
        w_rt_fwd = r_data[w_scan_idx];
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.regWrite  = r_regwrite;
  assign bus.writeReg  = r_writereg;
  assign bus.writeData = r_writedata;
  assign bus.rs_hit    = w_rs_hit;
  assign bus.rs_fwd    = w_rs_fwd;
  assign bus.rt_hit    = w_rt_hit;
  assign bus.rt_fwd    = w_rt_fwd;
  assign bus.count     = w_count;

endmodule
`default_nettype wire
